sram_bus_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM between instruction fetch (IF) and

---
 rtl/sram_bus_arbiter_pkg.sv | 11 +
 rtl/sram_arb_prio.sv | 11 +
 rtl/sram_bus_arbiter.sv | 75 +++++++
 tb/tb_sram_bus_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg: shared SRAM bus widths, EX burst limit and owner encodings
package sram_bus_arbiter_pkg;
  localparam int SramAddrBus = 32;
  localparam int SramBus = 32;
  localparam int MaxExBurst = 4;
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF_RD = 2'd1,
    OWN_EX_RD = 2'd2
  } owner_e;
endpackage

// File: rtl/sram_arb_prio.sv
// sram_arb_prio: comb EX-first grant with IF override when the EX streak is full; ports: if_req_i, ex_req_i, burst_full_i -> if_gnt_o, ex_gnt_o
module sram_arb_prio (
  input  logic if_req_i,
  input  logic ex_req_i,
  input  logic burst_full_i,
  output logic if_gnt_o,
  output logic ex_gnt_o
);
  assign ex_gnt_o = ex_req_i & ~(if_req_i & burst_full_i);
  assign if_gnt_o = if_req_i & ~ex_gnt_o;
endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sync SRAM between IF reads and EX load/store, returns read data 1 cycle after grant; ports: if_*, ex_*, mem_*, hold_flag_o
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = SramAddrBus,
  parameter int DATA_W = SramBus,
  parameter int MAX_EX_BURST = MaxExBurst
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              ex_gnt_o,
  output logic              ex_rvalid_o,
  output logic [DATA_W-1:0] ex_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              hold_flag_o
);
  localparam int SW = $clog2(MAX_EX_BURST + 1);
  logic          w_if_req;
  logic          w_ex_req;
  logic          w_if_gnt;
  logic          w_ex_gnt;
  logic          w_burst_full;
  logic [SW-1:0] r_streak;
  logic [SW-1:0] w_streak_nxt;
  owner_e        r_owner;
  owner_e        w_owner_nxt;
  assign w_if_req = if_req_i & ~rst;
  assign w_ex_req = ex_req_i & ~rst;
  assign w_burst_full = r_streak == SW'(MAX_EX_BURST);
  sram_arb_prio u_prio (
    .if_req_i    (w_if_req),
    .ex_req_i    (w_ex_req),
    .burst_full_i(w_burst_full),
    .if_gnt_o    (w_if_gnt),
    .ex_gnt_o    (w_ex_gnt)
  );
  always_comb begin
    w_streak_nxt = (!w_if_req || w_if_gnt) ? '0 :
                   (w_ex_gnt && !w_burst_full) ? r_streak + 1'b1 : r_streak;
    w_owner_nxt = w_if_gnt ? OWN_IF_RD : (w_ex_gnt && !ex_we_i) ? OWN_EX_RD : OWN_NONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
      r_owner <= OWN_NONE;
    end else begin
      r_streak <= w_streak_nxt;
      r_owner <= w_owner_nxt;
    end
  end
  assign if_gnt_o = w_if_gnt;
  assign ex_gnt_o = w_ex_gnt;
  assign hold_flag_o = w_if_req & ~w_if_gnt;
  assign mem_en_o = w_if_gnt | w_ex_gnt;
  assign mem_we_o = w_ex_gnt & ex_we_i;
  assign mem_addr_o = w_ex_gnt ? ex_addr_i : w_if_gnt ? if_addr_i : '0;
  assign mem_wdata_o = w_ex_gnt ? ex_wdata_i : '0;
  assign if_rvalid_o = r_owner == OWN_IF_RD;
  assign ex_rvalid_o = r_owner == OWN_EX_RD;
  assign if_rdata_o = if_rvalid_o ? mem_rdata_i : '0;
  assign ex_rdata_o = ex_rvalid_o ? mem_rdata_i : '0;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed-vector self-checking bench for sram_bus_arbiter with a small sync RAM model
module tb_sram_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ex_req = 1'b0;
  logic        ex_we = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic        ex_gnt;
  logic        ex_rvalid;
  logic [31:0] ex_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        hold_flag;
  logic [31:0] ram [0:255];
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  sram_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ex_req_i(ex_req), .ex_we_i(ex_we), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .ex_gnt_o(ex_gnt), .ex_rvalid_o(ex_rvalid), .ex_rdata_o(ex_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .hold_flag_o(hold_flag)
  );
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    @(negedge clk);
    if_req = 1'b0;
    ex_req = 1'b0;
    ex_we = 1'b0;
    @(negedge clk);
  endtask
  task automatic burst(input string tag, input int n);
    if_req = 1'b1;
    if_addr = 32'h10;
    ex_req = 1'b1;
    ex_we = 1'b0;
    ex_addr = 32'h40;
    for (int i = 0; i < n; i++) begin
      #1;
      chk(tag, {30'd0, if_gnt, ex_gnt}, (i % 5 == 4) ? 32'd2 : 32'd1);
      @(negedge clk);
    end
    if_req = 1'b0;
    ex_req = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 | i;
    @(negedge clk);
    if_req = 1'b1;
    ex_req = 1'b1;
    #1;
    chk("rst_gnt", {30'd0, if_gnt, ex_gnt}, 32'd0);
    chk("rst_en", {31'd0, mem_en}, 32'd0);
    chk("rst_hold", {31'd0, hold_flag}, 32'd0);
    chk("rst_rv", {30'd0, if_rvalid, ex_rvalid}, 32'd0);
    @(negedge clk);
    if_req = 1'b0;
    ex_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h10;
    #1;
    chk("t1_gnt", {31'd0, if_gnt}, 32'd1);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_we", {30'd0, mem_en, mem_we}, 32'd2);
    chk("t1_hold", {31'd0, hold_flag}, 32'd0);
    @(negedge clk);
    chk("t1_rv", {30'd0, if_rvalid, ex_rvalid}, 32'd2);
    chk("t1_rdata", if_rdata, 32'hC0DE_0010);
    chk("t1_hold2", {31'd0, hold_flag}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h10;
    ex_req = 1'b1;
    ex_we = 1'b0;
    ex_addr = 32'h40;
    #1;
    chk("t2_gnt", {30'd0, if_gnt, ex_gnt}, 32'd1);
    chk("t2_hold", {31'd0, hold_flag}, 32'd1);
    chk("t2_addr", mem_addr, 32'h40);
    @(negedge clk);
    chk("t2_rv", {30'd0, if_rvalid, ex_rvalid}, 32'd1);
    chk("t2_rdata", ex_rdata, 32'hC0DE_0040);
    chk("t2_ifrdata", if_rdata, 32'd0);
    idle();
    burst("t3_burst", 10);
    idle();
    ex_req = 1'b1;
    ex_we = 1'b1;
    ex_addr = 32'h20;
    ex_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t4_wr", {29'd0, ex_gnt, mem_en, mem_we}, 32'd7);
    chk("t4_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t4_waddr", mem_addr, 32'h20);
    @(negedge clk);
    chk("t4_wrv", {30'd0, if_rvalid, ex_rvalid}, 32'd0);
    ex_we = 1'b0;
    #1;
    chk("t4_rdwe", {30'd0, mem_en, mem_we}, 32'd2);
    @(negedge clk);
    chk("t4_rv", {31'd0, ex_rvalid}, 32'd1);
    chk("t4_rdata", ex_rdata, 32'hDEAD_BEEF);
    idle();
    if_req = 1'b1;
    if_addr = 32'h10;
    #1;
    chk("t5_gnt", {31'd0, if_gnt}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rv", {30'd0, if_rvalid, ex_rvalid}, 32'd0);
    chk("t5_rdata", if_rdata, 32'd0);
    chk("t5_out", {28'd0, if_gnt, mem_en, hold_flag, mem_we}, 32'd0);
    chk("t5_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if_addr = 32'h11;
    #1;
    chk("t5_regnt", {31'd0, if_gnt}, 32'd1);
    @(negedge clk);
    chk("t5_rerv", {31'd0, if_rvalid}, 32'd1);
    chk("t5_rerdata", if_rdata, 32'hC0DE_0011);
    if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t6_idle", {29'd0, mem_en, if_rvalid, ex_rvalid}, 32'd0);
      chk("t6_rdata", if_rdata | ex_rdata, 32'd0);
    end
    @(negedge clk);
    burst("t6_streak", 5);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
